// File: rtl/lsu.sv
// lsu: handshaked load/store bus master for the multi-cycle npc core.
// Accepts one access, drives a strobed XLEN bus, returns extended data.
module lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int SW = XLEN / 8;
  localparam int OW = $clog2(SW);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic          wr_q;
  logic [2:0]    op_q;
  logic [OW-1:0] off_q;
  logic [OW-1:0] off;
  logic          illegal;
  logic          misalign;
  logic          bad;
  logic [SW-1:0] mask;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] ld_data;
  logic [6:0]    sh;
  logic          full;
  logic          accept;

  assign off    = req_addr[OW-1:0];
  assign accept = (state == IDLE) && req_valid;
  assign bad    = illegal | misalign;

  always_comb begin
    illegal = 1'b0;
    if (req_op == 3'b111)
      illegal = 1'b1;
    if (req_wr && req_op[2])
      illegal = 1'b1;
    if (XLEN == 32 && (req_op == 3'b011 || req_op == 3'b110))
      illegal = 1'b1;
  end

  always_comb begin
    misalign = 1'b0;
    mask     = SW'(8'h01);
    unique case (req_op[1:0])
      2'd0: begin
        misalign = 1'b0;
        mask     = SW'(8'h01);
      end
      2'd1: begin
        misalign = req_addr[0];
        mask     = SW'(8'h03);
      end
      2'd2: begin
        misalign = |req_addr[1:0];
        mask     = SW'(8'h0F);
      end
      2'd3: begin
        misalign = |req_addr[2:0];
        mask     = SW'(8'hFF);
      end
      default: ;
    endcase
  end

  // Left-justify the access, then shift back down to sign- or zero-fill.
  always_comb begin
    raw  = mem_rdata >> {off_q, 3'b000};
    sh   = 7'(XLEN) - (7'd8 << op_q[1:0]);
    full = (op_q[1:0] == 2'd3) ||
           (XLEN == 32 && op_q[1:0] == 2'd2);
    if (full)
      ld_data = raw;
    else if (!op_q[2])
      ld_data = $signed(raw << sh) >>> sh;
    else
      ld_data = (raw << sh) >> sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_valid) state_nxt = bad ? RESP : REQ;
      REQ:  if (mem_req_ready) state_nxt = WAIT;
      WAIT: if (mem_resp_valid) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready     = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign resp_valid    = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b0;
      op_q       <= 3'b000;
      off_q      <= '0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      if (accept) begin
        wr_q       <= req_wr;
        op_q       <= req_op;
        off_q      <= off;
        resp_err   <= bad;
        resp_rdata <= '0;
        if (!bad) begin
          mem_addr  <= {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
          mem_wen   <= req_wr;
          mem_wstrb <= req_wr ? (mask << off) : '0;
          mem_wdata <= req_wr ? (req_wdata << {off, 3'b000}) : '0;
        end
      end
      if (state == WAIT && mem_resp_valid)
        resp_rdata <= wr_q ? '0 : ld_data;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed checks of lsu at XLEN=32 and XLEN=64.
// Walks loads, stores, errors, back-pressure and mid-flight reset.
module tb_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_wr;
  logic [2:0]  a_req_op;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_wen;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        a_mem_resp_valid;
  logic [31:0] a_mem_rdata;

  logic        b_req_valid, b_req_ready, b_req_wr;
  logic [2:0]  b_req_op;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [63:0] b_resp_rdata;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_wen;
  logic [31:0] b_mem_addr;
  logic [63:0] b_mem_wdata;
  logic [7:0]  b_mem_wstrb;
  logic        b_mem_resp_valid;
  logic [63:0] b_mem_rdata;

  lsu #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_wr(a_req_wr), .req_op(a_req_op),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
    .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_resp_valid(a_mem_resp_valid), .mem_rdata(a_mem_rdata)
  );

  lsu #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_wr(b_req_wr), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_resp_valid(b_mem_resp_valid), .mem_rdata(b_mem_rdata)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Best-case bus partner: ready always high, response the cycle after.
  task automatic xact(input bit w64, input logic wr, input logic [2:0] op,
                      input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [63:0] rdata,
                      output logic [63:0] rd, output logic err,
                      output int lat, output bit saw_bus,
                      output logic [31:0] maddr, output logic [63:0] mwdata,
                      output logic [7:0] mstrb, output logic mwen);
    bit pend;
    a_req_wr = wr; a_req_op = op; a_req_addr = addr;
    a_req_wdata = wdata[31:0]; a_mem_rdata = rdata[31:0];
    b_req_wr = wr; b_req_op = op; b_req_addr = addr;
    b_req_wdata = wdata; b_mem_rdata = rdata;
    a_req_valid = !w64;
    b_req_valid = w64;
    tick();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    a_mem_req_ready = 1'b1;
    b_mem_req_ready = 1'b1;
    lat = 1;
    pend = 1'b0;
    saw_bus = 1'b0;
    maddr  = w64 ? b_mem_addr : a_mem_addr;
    mwdata = w64 ? b_mem_wdata : {32'h0, a_mem_wdata};
    mstrb  = w64 ? b_mem_wstrb : {4'h0, a_mem_wstrb};
    mwen   = w64 ? b_mem_wen : a_mem_wen;
    while (!(w64 ? b_resp_valid : a_resp_valid) && lat < 20) begin
      if (w64 ? b_mem_req_valid : a_mem_req_valid)
        saw_bus = 1'b1;
      a_mem_resp_valid = pend && !w64;
      b_mem_resp_valid = pend && w64;
      pend = w64 ? b_mem_req_valid : a_mem_req_valid;
      tick();
      lat++;
    end
    rd  = w64 ? b_resp_rdata : {32'h0, a_resp_rdata};
    err = w64 ? b_resp_err : a_resp_err;
    a_mem_resp_valid = 1'b0;
    b_mem_resp_valid = 1'b0;
    a_mem_req_ready = 1'b0;
    b_mem_req_ready = 1'b0;
  endtask

  logic [63:0] rd, mwdata;
  logic [31:0] maddr;
  logic [7:0]  mstrb;
  logic        err, mwen;
  int          lat;
  bit          saw;
  bit          stable;

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_wr = 0; a_req_op = 0; a_req_addr = 0;
    a_req_wdata = 0; a_mem_req_ready = 0; a_mem_resp_valid = 0;
    a_mem_rdata = 0;
    b_req_valid = 0; b_req_wr = 0; b_req_op = 0; b_req_addr = 0;
    b_req_wdata = 0; b_mem_req_ready = 0; b_mem_resp_valid = 0;
    b_mem_rdata = 0;
    #1;
    check("rst_req_ready", 64'(a_req_ready), 64'd1);
    check("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    check("rst_mem_req_valid", 64'(a_mem_req_valid), 64'd0);
    check("rst_mem_addr", 64'(a_mem_addr), 64'd0);
    check("rst_mem_wstrb", 64'(a_mem_wstrb), 64'd0);
    check("rst_req_ready64", 64'(b_req_ready), 64'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // lb at 0x1003
    xact(0, 0, 3'b000, 32'h1003, 64'h0, 64'h80123456,
         rd, err, lat, saw, maddr, mwdata, mstrb, mwen);
    check("lb_lat", 64'(lat), 64'd3);
    check("lb_addr", 64'(maddr), 64'h1000);
    check("lb_wstrb", 64'(mstrb), 64'h0);
    check("lb_wen", 64'(mwen), 64'd0);
    check("lb_rdata", rd, 64'hFFFFFF80);
    check("lb_err", 64'(err), 64'd0);
    tick();
    check("lb_resp_drop", 64'(a_resp_valid), 64'd0);
    check("lb_ready_back", 64'(a_req_ready), 64'd1);

    // sh at 0x2002
    xact(0, 1, 3'b001, 32'h2002, 64'hDEADBEEF, 64'h0,
         rd, err, lat, saw, maddr, mwdata, mstrb, mwen);
    check("sh_wdata", mwdata, 64'hBEEF0000);
    check("sh_wstrb", 64'(mstrb), 64'hC);
    check("sh_wen", 64'(mwen), 64'd1);
    check("sh_addr", 64'(maddr), 64'h2000);
    check("sh_rdata", rd, 64'h0);
    check("sh_err", 64'(err), 64'd0);
    check("sh_lat", 64'(lat), 64'd3);
    tick();

    // misaligned lw
    xact(0, 0, 3'b010, 32'h3001, 64'h0, 64'h12345678,
         rd, err, lat, saw, maddr, mwdata, mstrb, mwen);
    check("lw_mis_err", 64'(err), 64'd1);
    check("lw_mis_lat", 64'(lat), 64'd1);
    check("lw_mis_bus", 64'(saw), 64'd0);
    check("lw_mis_rdata", rd, 64'h0);
    tick();
    check("lw_mis_bus2", 64'(a_mem_req_valid), 64'd0);

    // ld illegal at XLEN=32
    xact(0, 0, 3'b011, 32'h3000, 64'h0, 64'h0,
         rd, err, lat, saw, maddr, mwdata, mstrb, mwen);
    check("ld32_err", 64'(err), 64'd1);
    check("ld32_lat", 64'(lat), 64'd1);
    tick();

    // XLEN=64 lwu / lw at 0x4004
    xact(1, 0, 3'b110, 32'h4004, 64'h0, 64'h9ABCDEF0_11223344,
         rd, err, lat, saw, maddr, mwdata, mstrb, mwen);
    check("lwu64_rdata", rd, 64'h00000000_9ABCDEF0);
    check("lwu64_err", 64'(err), 64'd0);
    check("lwu64_addr", 64'(maddr), 64'h4000);
    check("lwu64_lat", 64'(lat), 64'd3);
    tick();
    xact(1, 0, 3'b010, 32'h4004, 64'h0, 64'h9ABCDEF0_11223344,
         rd, err, lat, saw, maddr, mwdata, mstrb, mwen);
    check("lw64_rdata", rd, 64'hFFFFFFFF_9ABCDEF0);
    tick();

    // back-pressure: sw at 0x5004
    a_req_wr = 1; a_req_op = 3'b010; a_req_addr = 32'h5004;
    a_req_wdata = 32'h12345678; a_req_valid = 1;
    tick();
    a_req_valid = 0;
    a_mem_req_ready = 0;
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) a_mem_req_ready = 1;
      stable &= a_mem_req_valid && a_mem_addr == 32'h5004 &&
                a_mem_wdata == 32'h12345678 && a_mem_wstrb == 4'hF &&
                a_mem_wen && !a_req_ready && !a_resp_valid;
      tick();
    end
    a_mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) a_mem_resp_valid = 1;
      stable &= !a_mem_req_valid && a_mem_addr == 32'h5004 &&
                a_mem_wdata == 32'h12345678 && a_mem_wstrb == 4'hF &&
                a_mem_wen && !a_req_ready && !a_resp_valid;
      tick();
    end
    a_mem_resp_valid = 0;
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_resp", 64'(a_resp_valid), 64'd1);
    check("bp_ready_in_resp", 64'(a_req_ready), 64'd0);
    tick();
    check("bp_single_pulse", 64'(a_resp_valid), 64'd0);
    check("bp_ready_after", 64'(a_req_ready), 64'd1);

    // reset while in WAIT
    a_req_wr = 0; a_req_op = 3'b010; a_req_addr = 32'h6000;
    a_req_valid = 1;
    tick();
    a_req_valid = 0;
    a_mem_req_ready = 1;
    tick();
    a_mem_req_ready = 0;
    #2 rst = 1'b1;
    #1;
    check("wrst_ready", 64'(a_req_ready), 64'd1);
    check("wrst_addr", 64'(a_mem_addr), 64'd0);
    tick();
    rst = 1'b0;
    a_mem_resp_valid = 1;
    a_mem_rdata = 32'hFFFFFFFF;
    tick();
    a_mem_resp_valid = 0;
    check("stray_resp0", 64'(a_resp_valid), 64'd0);
    tick();
    check("stray_resp1", 64'(a_resp_valid), 64'd0);
    check("stray_ready", 64'(a_req_ready), 64'd1);
    xact(0, 0, 3'b100, 32'h0, 64'h0, 64'h000000FF,
         rd, err, lat, saw, maddr, mwdata, mstrb, mwen);
    check("lbu_rdata", rd, 64'h000000FF);
    check("lbu_lat", 64'(lat), 64'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
